dmem_sized: RTL

- Parametrised, byte-addressable data memory; next generation of the team's single-cycle word dmem.
- Supports byte, halfword and word (and doubleword when n=64) loads and stores, with sign or zero extension on loads and misalignment detection.
- Uses a valid/ready request port and a registered, one-cycle-latency response.
- Sits between the datapath's memory stage and the clock/reset tree.

---
 rtl/dmem_sized.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - byte-addressable data memory with sized accesses and a registered one-cycle response
// Optional DMEM_CLEAR_EN: zero the whole array after every reset before accepting requests.
module dmem_sized #(
  parameter int n = 32,
  parameter int r = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic         writeEnable,
  input  logic [1:0]   size,
  input  logic         signedLoad,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writeData,
  output logic [n-1:0] readData,
  output logic         respValid,
  output logic         fault
);
  localparam int B = n / 8;
  localparam int L = $clog2(B);

  logic [n-1:0] mem_q [2**r];

  logic [r-1:0] word_idx;
  logic [L-1:0] byte_off;
  logic         addr_unused;
  logic [L-1:0] align_mask;
  logic         fault_c;
  logic         accept;
  logic         st_we;
  logic [B-1:0] lane_en;
  logic [n-1:0] wr_data;
  logic [n-1:0] rd_shift;
  logic [n-1:0] keep_mask;
  logic         sign_bit;
  logic [n-1:0] load_result;
  logic         clr_we;
  logic [r-1:0] clr_idx;

  logic         respValid_q, respValid_d;
  logic         fault_q, fault_d;
  logic [n-1:0] readData_q, readData_d;

  // Upper address bits only select beyond the array and wrap away.
  assign word_idx    = addr[r+L-1:L];
  assign byte_off    = addr[L-1:0];
  assign addr_unused = ^addr[n-1:r+L];

  always_comb begin
    align_mask = L'((32'd1 << size) - 32'd1);
    fault_c    = (int'(size) > L) || ((byte_off & align_mask) != '0);
    accept     = reqValid && reqReady && !rst;
    st_we      = accept && writeEnable && !fault_c;
    lane_en    = B'(((32'd1 << (32'd1 << size)) - 32'd1) << byte_off);
    wr_data    = writeData << {byte_off, 3'b000};
  end

  // Load path: align selected bytes to bit 0, then zero- or sign-fill above.
  always_comb begin
    rd_shift  = mem_q[word_idx] >> {byte_off, 3'b000};
    keep_mask = (int'(size) >= L) ? '1 : ((n'(1) << (32'd8 << size)) - n'(1));
    case (size)
      2'd0:    sign_bit = rd_shift[7];
      2'd1:    sign_bit = rd_shift[15];
      default: sign_bit = rd_shift[31];
    endcase
    load_result = (rd_shift & keep_mask) | ((signedLoad && sign_bit) ? ~keep_mask : '0);
  end

  always_comb begin
    respValid_d = accept;
    fault_d     = accept && fault_c;
    readData_d  = readData_q;
    if (accept) begin
      if (fault_c)
        readData_d = '0;
      else if (!writeEnable)
        readData_d = load_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      respValid_q <= 1'b0;
      fault_q     <= 1'b0;
      readData_q  <= '0;
    end else begin
      respValid_q <= respValid_d;
      fault_q     <= fault_d;
      readData_q  <= readData_d;
    end
  end

  assign respValid = respValid_q;
  assign fault     = fault_q;
  assign readData  = readData_q;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else if (st_we) begin
      for (int k = 0; k < B; k++)
        if (lane_en[k])
          mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

`ifdef DMEM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t       state_q, state_d;
  logic [r-1:0] clear_idx_q, clear_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    if (state_q == S_CLEAR) begin
      clear_idx_d = clear_idx_q + r'(1);
      if (clear_idx_q == '1)
        state_d = S_IDLE;
    end
  end

  always_comb begin
    reqReady = (state_q == S_IDLE);
    clr_we   = (state_q == S_CLEAR) && !rst;
    clr_idx  = clear_idx_q;
  end
`else
  always_comb begin
    reqReady = !rst;
    clr_we   = 1'b0;
    clr_idx  = '0;
  end
`endif

endmodule
